// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM state encoding for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int CPU_WIDTH = 32;
  localparam logic [CPU_WIDTH-1:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [CPU_WIDTH-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a fetch, otherwise holds.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [CPU_WIDTH-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic                 i_load,
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic [CPU_WIDTH-1:0] i_inst,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic [CPU_WIDTH-1:0] o_inst,
  output logic                 o_valid
);

  logic [CPU_WIDTH-1:0] r_pc;
  logic [CPU_WIDTH-1:0] r_inst;
  logic                 r_valid;

  // Flush wins over load so a redirect always squashes the wrong-path fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_pc    <= i_pc;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_inst  <= i_inst;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, BOOT/RUN sequencing, redirect/stall handling.
// Optional FETCH_PERF_CNT_EN adds fetch and stall event counters.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   ST_BOOT | first cycle after reset release; IF/ID stays bubble
//   ST_RUN  | steady state: jump > stall > sequential advance
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [CPU_WIDTH-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 jump_en_i,
  input  logic [CPU_WIDTH-1:0] jump_addr_i,
  input  logic [CPU_WIDTH-1:0] inst_i,
  output logic [CPU_WIDTH-1:0] pc_addr_o,
  output logic [CPU_WIDTH-1:0] id_pc_o,
  output logic [CPU_WIDTH-1:0] id_inst_o,
  output logic                 id_valid_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]          fetch_cnt_o,
  output logic [31:0]          stall_cnt_o,
`endif
  output logic                 misalign_o
);

  fetch_state_e         r_state;
  fetch_state_e         w_state_nxt;
  logic [CPU_WIDTH-1:0] r_pc;
  logic [CPU_WIDTH-1:0] w_pc_nxt;
  logic                 r_misalign;
  logic                 w_misalign_nxt;
  logic                 w_load;
  logic                 w_flush;
  logic                 w_stall_cyc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  // A redirect is honoured in either state; the target is word-aligned by dropping addr[1:0].
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_misalign_nxt = 1'b0;
    w_load         = 1'b0;
    w_flush        = 1'b0;
    w_stall_cyc    = 1'b0;
    if (jump_en_i) begin
      w_state_nxt    = ST_RUN;
      w_pc_nxt       = {jump_addr_i[CPU_WIDTH-1:2], 2'b00};
      w_misalign_nxt = |jump_addr_i[1:0];
      w_flush        = 1'b1;
    end else begin
      unique case (r_state)
        ST_BOOT: w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (stall_i) begin
            w_stall_cyc = 1'b1;
          end else begin
            w_load   = 1'b1;
            w_pc_nxt = r_pc + PC_STEP;
          end
        end
        default: w_state_nxt = ST_BOOT;
      endcase
    end
  end

  fetch_unit_if_id_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_load  (w_load),
    .i_pc    (r_pc),
    .i_inst  (inst_i),
    .o_pc    (id_pc_o),
    .o_inst  (id_inst_o),
    .o_valid (id_valid_o)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_load)      r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall_cyc) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign stall_cnt_o = r_stall_cnt;
`endif

  assign pc_addr_o  = r_pc;
  assign misalign_o = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then randomized redirect/stall/reset traffic.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        misalign;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic [31:0] inst_i;
  logic [31:0] pc_addr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        misalign_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall_i),
    .jump_en_i   (jump_en_i),
    .jump_addr_i (jump_addr_i),
    .inst_i      (inst_i),
    .pc_addr_o   (pc_addr_o),
    .id_pc_o     (id_pc_o),
    .id_inst_o   (id_inst_o),
    .id_valid_o  (id_valid_o),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt_o (fetch_cnt_o),
    .stall_cnt_o (stall_cnt_o),
`endif
    .misalign_o  (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: the three preloaded words, then an address-derived pattern.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0: imem = 32'h11;
      32'h4: imem = 32'h22;
      32'h8: imem = 32'h33;
      default: imem = {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endcase
  endfunction

  assign inst_i = imem(pc_addr_o);

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
  endtask

  // Reference model: architectural view of PC, IF/ID and counters.
  logic [31:0] m_pc, m_idpc, m_idinst, m_fcnt, m_scnt;
  logic        m_boot, m_valid, m_mis;
  exp_t        sb[$];

  task automatic step(input logic rst, input logic stall, input logic jump, input logic [31:0] ja);
    exp_t e;
    @(negedge clk);
    rst_n       = ~rst;
    stall_i     = stall;
    jump_en_i   = jump;
    jump_addr_i = ja;
    if (rst) begin
      m_pc = RST_PC; m_idpc = RST_PC; m_idinst = NOP; m_valid = 1'b0;
      m_mis = 1'b0; m_boot = 1'b1; m_fcnt = 0; m_scnt = 0;
    end else if (jump) begin
      m_idpc = m_pc; m_idinst = NOP; m_valid = 1'b0;
      m_pc = ja & ~32'd3;
      m_mis = (ja % 4) != 0;
      m_boot = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_mis = 1'b0;
    end else if (stall) begin
      m_mis = 1'b0; m_scnt = m_scnt + 1;
    end else begin
      m_idpc = m_pc; m_idinst = imem(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 4; m_mis = 1'b0; m_fcnt = m_fcnt + 1;
    end
    e.pc = m_pc; e.id_pc = m_idpc; e.id_inst = m_idinst; e.id_valid = m_valid;
    e.misalign = m_mis; e.fcnt = m_fcnt; e.scnt = m_scnt;
    sb.push_back(e);
  endtask

  // Monitor: compares the DUT state after each edge against the queued expectation.
  exp_t e_mon;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      chk("pc_addr", pc_addr_o, e_mon.pc);
      chk("id_pc", id_pc_o, e_mon.id_pc);
      chk("id_inst", id_inst_o, e_mon.id_inst);
      chk("id_valid", {31'd0, id_valid_o}, {31'd0, e_mon.id_valid});
      chk("misalign", {31'd0, misalign_o}, {31'd0, e_mon.misalign});
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt_o, e_mon.fcnt);
      chk("stall_cnt", stall_cnt_o, e_mon.scnt);
`endif
    end
  end

  initial begin
    logic [31:0] ja;
    int          wait_cyc;
    rst_n = 1'b0; stall_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'd0;
    m_pc = RST_PC; m_idpc = RST_PC; m_idinst = NOP; m_valid = 1'b0;
    m_mis = 1'b0; m_boot = 1'b1; m_fcnt = 0; m_scnt = 0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);                       // BOOT bubble
    step(0, 0, 0, 0);                       // {0,0x11}
    step(0, 0, 0, 0);                       // {4,0x22}, pc=8
    repeat (3) step(0, 1, 0, 0);            // hold at pc=8
    step(0, 0, 0, 0);                       // {8,0x33}
    step(0, 1, 1, 32'h40);                  // jump beats stall
    step(0, 0, 0, 0);                       // id_pc=0x40
    step(0, 0, 1, 32'h42);                  // misaligned target
    step(0, 0, 0, 0);                       // misalign pulse drops
    step(0, 0, 1, 32'h44);                  // back-to-back jumps
    step(0, 0, 1, 32'h13);
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);                       // pc wraps to 0
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h1C);
    step(0, 0, 0, 0);                       // pc=0x20
    step(1, 0, 0, 0);                       // mid-stream reset
    step(0, 0, 1, 32'h80);                  // jump during BOOT
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);                       // stall during BOOT is ignored

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       ja = $urandom();
        1:       ja = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: ja = $urandom_range(0, 255);
      endcase
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 15, ja);
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) chk("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
